// File: rtl/orchestrator_wrapper.sv
// AXI4 pass-through that serialises one transaction at a time and mirrors every
// data beat onto an AXI-Stream monitor port. DATA_W is expected to be 32 or 64.
module orchestrator_wrapper #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 1
) (
  input  logic                aclk_0,
  input  logic                aresetn_0,
  // slave write address
  input  logic [ID_W-1:0]     s_axi_awid,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic [7:0]          s_axi_awlen,
  input  logic [2:0]          s_axi_awsize,
  input  logic [1:0]          s_axi_awburst,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  // slave write data
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wlast,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  // slave write response
  output logic [ID_W-1:0]     s_axi_bid,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  // slave read address
  input  logic [ID_W-1:0]     s_axi_arid,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic [7:0]          s_axi_arlen,
  input  logic [2:0]          s_axi_arsize,
  input  logic [1:0]          s_axi_arburst,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  // slave read data
  output logic [ID_W-1:0]     s_axi_rid,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rlast,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready,
  // master write address
  output logic [ID_W-1:0]     m_axi_awid,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  // master write data
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  // master write response
  input  logic [ID_W-1:0]     m_axi_bid,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  // master read address
  output logic [ID_W-1:0]     m_axi_arid,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [7:0]          m_axi_arlen,
  output logic [2:0]          m_axi_arsize,
  output logic [1:0]          m_axi_arburst,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  // master read data
  input  logic [ID_W-1:0]     m_axi_rid,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rlast,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready,
  // monitor stream
  output logic [DATA_W-1:0]   m_axis_tdata,
  output logic [DATA_W/8-1:0] m_axis_tkeep,
  output logic [0:0]          m_axis_tuser,
  output logic                m_axis_tlast,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  // FSM state observation
  output logic [2:0]          dbg_state
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_ADDR = 3'd1;
  localparam logic [2:0] ST_WR_DATA = 3'd2;
  localparam logic [2:0] ST_WR_RESP = 3'd3;
  localparam logic [2:0] ST_RD_ADDR = 3'd4;
  localparam logic [2:0] ST_RD_DATA = 3'd5;

  // Handshake rule used throughout: a transfer happens on the rising edge where
  // valid and ready are both high; a valid, once raised, is held until it transfers.

  logic [2:0]        state_q, state_d;
  logic              active_q, active_d;
  logic [ID_W-1:0]   aw_id_q, aw_id_d;
  logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
  logic [7:0]        aw_len_q, aw_len_d;
  logic [2:0]        aw_size_q, aw_size_d;
  logic [1:0]        aw_burst_q, aw_burst_d;
  logic [ID_W-1:0]   ar_id_q, ar_id_d;
  logic [ADDR_W-1:0] ar_addr_q, ar_addr_d;
  logic [7:0]        ar_len_q, ar_len_d;
  logic [2:0]        ar_size_q, ar_size_d;
  logic [1:0]        ar_burst_q, ar_burst_d;

  logic st_idle, st_wr_addr, st_wr_data, st_wr_resp, st_rd_addr, st_rd_data;
  logic ar_fire, aw_fire, w_beat, r_beat, b_fire;

  assign st_idle    = (state_q == ST_IDLE);
  assign st_wr_addr = (state_q == ST_WR_ADDR);
  assign st_wr_data = (state_q == ST_WR_DATA);
  assign st_wr_resp = (state_q == ST_WR_RESP);
  assign st_rd_addr = (state_q == ST_RD_ADDR);
  assign st_rd_data = (state_q == ST_RD_DATA);

  // active_q keeps the address readies low while in reset without a
  // combinational path from the reset input.
  assign s_axi_arready = st_idle & active_q;
  assign s_axi_awready = st_idle & active_q & ~s_axi_arvalid;

  assign ar_fire = s_axi_arvalid & s_axi_arready;
  assign aw_fire = s_axi_awvalid & s_axi_awready;
  assign w_beat  = st_wr_data & s_axi_wvalid & m_axi_wready & m_axis_tready;
  assign r_beat  = st_rd_data & m_axi_rvalid & s_axi_rready & m_axis_tready;
  assign b_fire  = st_wr_resp & m_axi_bvalid & s_axi_bready;

  assign m_axi_awid    = aw_id_q;
  assign m_axi_awaddr  = aw_addr_q;
  assign m_axi_awlen   = aw_len_q;
  assign m_axi_awsize  = aw_size_q;
  assign m_axi_awburst = aw_burst_q;
  assign m_axi_awvalid = st_wr_addr;

  assign m_axi_arid    = ar_id_q;
  assign m_axi_araddr  = ar_addr_q;
  assign m_axi_arlen   = ar_len_q;
  assign m_axi_arsize  = ar_size_q;
  assign m_axi_arburst = ar_burst_q;
  assign m_axi_arvalid = st_rd_addr;

  // Three-way joins: each party sees valid/ready only when the other two are ready.
  assign m_axi_wdata  = s_axi_wdata;
  assign m_axi_wstrb  = s_axi_wstrb;
  assign m_axi_wlast  = s_axi_wlast;
  assign m_axi_wvalid = st_wr_data & s_axi_wvalid & m_axis_tready;
  assign s_axi_wready = st_wr_data & m_axi_wready & m_axis_tready;

  assign s_axi_bid    = m_axi_bid;
  assign s_axi_bresp  = m_axi_bresp;
  assign s_axi_bvalid = st_wr_resp & m_axi_bvalid;
  assign m_axi_bready = st_wr_resp & s_axi_bready;

  assign s_axi_rid    = m_axi_rid;
  assign s_axi_rdata  = m_axi_rdata;
  assign s_axi_rresp  = m_axi_rresp;
  assign s_axi_rlast  = m_axi_rlast;
  assign s_axi_rvalid = st_rd_data & m_axi_rvalid & m_axis_tready;
  assign m_axi_rready = st_rd_data & s_axi_rready & m_axis_tready;

  assign m_axis_tvalid = (st_wr_data & s_axi_wvalid & m_axi_wready) |
                         (st_rd_data & m_axi_rvalid & s_axi_rready);
  assign m_axis_tdata  = st_rd_data ? m_axi_rdata : s_axi_wdata;
  assign m_axis_tkeep  = st_rd_data ? {(DATA_W/8){1'b1}} : s_axi_wstrb;
  assign m_axis_tuser  = st_wr_data;
  assign m_axis_tlast  = st_rd_data ? m_axi_rlast : s_axi_wlast;

  assign dbg_state = state_q;

  always_comb begin
    state_d    = state_q;
    active_d   = 1'b1;
    aw_id_d    = aw_id_q;
    aw_addr_d  = aw_addr_q;
    aw_len_d   = aw_len_q;
    aw_size_d  = aw_size_q;
    aw_burst_d = aw_burst_q;
    ar_id_d    = ar_id_q;
    ar_addr_d  = ar_addr_q;
    ar_len_d   = ar_len_q;
    ar_size_d  = ar_size_q;
    ar_burst_d = ar_burst_q;
    case (state_q)
      ST_IDLE: begin
        if (ar_fire) begin
          state_d    = ST_RD_ADDR;
          ar_id_d    = s_axi_arid;
          ar_addr_d  = s_axi_araddr;
          ar_len_d   = s_axi_arlen;
          ar_size_d  = s_axi_arsize;
          ar_burst_d = s_axi_arburst;
        end else if (aw_fire) begin
          state_d    = ST_WR_ADDR;
          aw_id_d    = s_axi_awid;
          aw_addr_d  = s_axi_awaddr;
          aw_len_d   = s_axi_awlen;
          aw_size_d  = s_axi_awsize;
          aw_burst_d = s_axi_awburst;
        end
      end
      ST_WR_ADDR: if (m_axi_awready) state_d = ST_WR_DATA;
      ST_WR_DATA: if (w_beat && s_axi_wlast) state_d = ST_WR_RESP;
      ST_WR_RESP: if (b_fire) state_d = ST_IDLE;
      ST_RD_ADDR: if (m_axi_arready) state_d = ST_RD_DATA;
      ST_RD_DATA: if (r_beat && m_axi_rlast) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk_0) begin
    if (aresetn_0) begin
      state_q    <= ST_IDLE;
      active_q   <= 1'b0;
      aw_id_q    <= '0;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_size_q  <= '0;
      aw_burst_q <= '0;
      ar_id_q    <= '0;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
    end else begin
      state_q    <= state_d;
      active_q   <= active_d;
      aw_id_q    <= aw_id_d;
      aw_addr_q  <= aw_addr_d;
      aw_len_q   <= aw_len_d;
      aw_size_q  <= aw_size_d;
      aw_burst_q <= aw_burst_d;
      ar_id_q    <= ar_id_d;
      ar_addr_q  <= ar_addr_d;
      ar_len_q   <= ar_len_d;
      ar_size_q  <= ar_size_d;
      ar_burst_q <= ar_burst_d;
    end
  end

endmodule

// File: tb/tb_orchestrator_wrapper.sv
// Bench for orchestrator_wrapper: behavioural AXI master, memory slave and stream
// sink, with expected queues built from the issued transactions.
module tb_orchestrator_wrapper;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int IW = 1;

  logic aclk_0 = 1'b0;
  always #5 aclk_0 = ~aclk_0;
  logic aresetn_0;

  logic [IW-1:0] s_axi_awid, s_axi_arid, s_axi_bid, s_axi_rid;
  logic [AW-1:0] s_axi_awaddr, s_axi_araddr;
  logic [7:0] s_axi_awlen, s_axi_arlen;
  logic [2:0] s_axi_awsize, s_axi_arsize;
  logic [1:0] s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
  logic s_axi_awvalid, s_axi_awready, s_axi_arvalid, s_axi_arready;
  logic [DW-1:0] s_axi_wdata, s_axi_rdata;
  logic [DW/8-1:0] s_axi_wstrb;
  logic s_axi_wlast, s_axi_wvalid, s_axi_wready, s_axi_bvalid, s_axi_bready;
  logic s_axi_rlast, s_axi_rvalid, s_axi_rready;
  logic [IW-1:0] m_axi_awid, m_axi_arid, m_axi_bid, m_axi_rid;
  logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
  logic [7:0] m_axi_awlen, m_axi_arlen;
  logic [2:0] m_axi_awsize, m_axi_arsize;
  logic [1:0] m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
  logic m_axi_awvalid, m_axi_awready, m_axi_arvalid, m_axi_arready;
  logic [DW-1:0] m_axi_wdata, m_axi_rdata;
  logic [DW/8-1:0] m_axi_wstrb;
  logic m_axi_wlast, m_axi_wvalid, m_axi_wready, m_axi_bvalid, m_axi_bready;
  logic m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic [DW-1:0] m_axis_tdata;
  logic [DW/8-1:0] m_axis_tkeep;
  logic [0:0] m_axis_tuser;
  logic m_axis_tlast, m_axis_tvalid, m_axis_tready;
  logic [2:0] dbg_state;

  orchestrator_wrapper #(.DATA_W(DW), .ADDR_W(AW), .ID_W(IW)) dut (
    .aclk_0(aclk_0), .aresetn_0(aresetn_0),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mw_beats = 0;
  int tr_mode = 0;
  logic rnd_en = 1'b0;

  // Memory behind m_axi, word addressed, 256 words wrapping.
  logic [31:0] mem [0:255];

  // Expected-value queues (scoreboard) and behavioural driver state.
  logic [45:0] exp_ar_q[$], exp_aw_q[$];
  logic [35:0] exp_r_q[$], slv_r_q[$];
  logic [36:0] exp_mw_q[$], w_q[$];
  logic [37:0] exp_t_q[$];
  logic [2:0]  exp_b_q[$], slv_b_q[$];
  logic ar_pend = 1'b0, aw_pend = 1'b0;
  logic [1:0] cur_rresp = 2'b00, cur_bresp = 2'b00;
  logic [7:0] slv_waddr = 8'h0;
  logic slv_wid = 1'b0;
  logic [31:0] dir_w [0:1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic coin();
    return rnd_en ? ($urandom_range(0, 3) != 0) : 1'b1;
  endfunction

  task automatic clear_env();
    exp_ar_q.delete(); exp_aw_q.delete(); exp_r_q.delete(); slv_r_q.delete();
    exp_mw_q.delete(); w_q.delete(); exp_t_q.delete(); exp_b_q.delete(); slv_b_q.delete();
    ar_pend = 1'b0; aw_pend = 1'b0;
    s_axi_arvalid = 1'b0; s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    m_axi_rvalid = 1'b0; m_axi_bvalid = 1'b0;
  endtask

  // One clock: observe and score at the falling edge, drive after the rising edge.
  task automatic step();
    logic s_ar_f, s_aw_f, m_ar_f, m_aw_f, s_w_f, m_w_f, s_r_f, m_r_f, s_b_f, m_b_f, t_f;
    logic [7:0] idx;
    @(negedge aclk_0);
    s_ar_f = 1'b0; s_aw_f = 1'b0; m_ar_f = 1'b0; m_aw_f = 1'b0; s_w_f = 1'b0;
    m_w_f = 1'b0; s_r_f = 1'b0; m_r_f = 1'b0; s_b_f = 1'b0; m_b_f = 1'b0; t_f = 1'b0;
    if (!aresetn_0) begin
      s_ar_f = s_axi_arvalid & s_axi_arready;
      s_aw_f = s_axi_awvalid & s_axi_awready;
      m_ar_f = m_axi_arvalid & m_axi_arready;
      m_aw_f = m_axi_awvalid & m_axi_awready;
      s_w_f  = s_axi_wvalid & s_axi_wready;
      m_w_f  = m_axi_wvalid & m_axi_wready;
      s_r_f  = s_axi_rvalid & s_axi_rready;
      m_r_f  = m_axi_rvalid & m_axi_rready;
      s_b_f  = s_axi_bvalid & s_axi_bready;
      m_b_f  = m_axi_bvalid & m_axi_bready;
      t_f    = m_axis_tvalid & m_axis_tready;
      if (!m_axis_tready)
        chk("stall_while_tready_low", {s_axi_wready, m_axi_wvalid, s_axi_rvalid, m_axi_rready}, 4'b0);
      if (s_axi_arvalid) chk("ar_priority_awready", s_axi_awready, 1'b0);
      if (m_axis_tvalid) chk("tvalid_only_with_pending_beat", exp_t_q.size() > 0, 1'b1);
      if (s_w_f || m_w_f) chk("w_join", s_w_f, m_w_f);
      if (s_r_f || m_r_f) chk("r_join", s_r_f, m_r_f);
      if (s_w_f || s_r_f) chk("beat_on_stream", t_f, 1'b1);
      if (s_aw_f) chk("aw_after_read_done", exp_r_q.size(), 0);
      if (m_ar_f) begin
        chk("m_ar_pending", exp_ar_q.size() > 0, 1'b1);
        if (exp_ar_q.size() > 0)
          chk("m_ar_fields", {m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst},
              exp_ar_q.pop_front());
        for (int i = 0; i <= int'(m_axi_arlen); i++) begin
          idx = m_axi_araddr[9:2] + i[7:0];
          slv_r_q.push_back({m_axi_arid, cur_rresp, (i == int'(m_axi_arlen)), mem[idx]});
        end
      end
      if (m_aw_f) begin
        chk("m_aw_pending", exp_aw_q.size() > 0, 1'b1);
        if (exp_aw_q.size() > 0)
          chk("m_aw_fields", {m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst},
              exp_aw_q.pop_front());
        slv_waddr = m_axi_awaddr[9:2];
        slv_wid = m_axi_awid;
      end
      if (m_w_f) begin
        chk("m_w_pending", exp_mw_q.size() > 0, 1'b1);
        if (exp_mw_q.size() > 0)
          chk("m_w_beat", {m_axi_wstrb, m_axi_wlast, m_axi_wdata}, exp_mw_q.pop_front());
        for (int b = 0; b < 4; b++)
          if (m_axi_wstrb[b]) mem[slv_waddr][8*b +: 8] = m_axi_wdata[8*b +: 8];
        slv_waddr = slv_waddr + 8'd1;
        mw_beats++;
        if (m_axi_wlast) slv_b_q.push_back({slv_wid, cur_bresp});
      end
      if (t_f) begin
        chk("t_pending", exp_t_q.size() > 0, 1'b1);
        if (exp_t_q.size() > 0)
          chk("t_beat", {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata}, exp_t_q.pop_front());
      end
      if (s_r_f) begin
        chk("s_r_pending", exp_r_q.size() > 0, 1'b1);
        if (exp_r_q.size() > 0)
          chk("s_r_beat", {s_axi_rid, s_axi_rresp, s_axi_rlast, s_axi_rdata}, exp_r_q.pop_front());
      end
      if (s_b_f) begin
        chk("s_b_pending", exp_b_q.size() > 0, 1'b1);
        if (exp_b_q.size() > 0) chk("s_b_resp", {s_axi_bid, s_axi_bresp}, exp_b_q.pop_front());
      end
      if (s_ar_f) ar_pend = 1'b0;
      if (s_aw_f) aw_pend = 1'b0;
      if (s_w_f && w_q.size() > 0) void'(w_q.pop_front());
      if (m_r_f && slv_r_q.size() > 0) void'(slv_r_q.pop_front());
      if (m_b_f && slv_b_q.size() > 0) void'(slv_b_q.pop_front());
    end
    @(posedge aclk_0);
    #1;
    cyc++;
    s_axi_arvalid = ar_pend;
    s_axi_awvalid = aw_pend;
    if (!s_axi_wvalid || s_w_f) s_axi_wvalid = (w_q.size() > 0) && coin();
    if (w_q.size() > 0) {s_axi_wstrb, s_axi_wlast, s_axi_wdata} = w_q[0];
    if (!m_axi_rvalid || m_r_f) m_axi_rvalid = (slv_r_q.size() > 0) && coin();
    if (slv_r_q.size() > 0) {m_axi_rid, m_axi_rresp, m_axi_rlast, m_axi_rdata} = slv_r_q[0];
    if (!m_axi_bvalid || m_b_f) m_axi_bvalid = (slv_b_q.size() > 0) && coin();
    if (slv_b_q.size() > 0) {m_axi_bid, m_axi_bresp} = slv_b_q[0];
    s_axi_rready = coin();
    s_axi_bready = coin();
    m_axi_arready = coin();
    m_axi_awready = coin();
    m_axi_wready = coin();
    case (tr_mode)
      1:       m_axis_tready = ($urandom_range(0, 2) != 0);
      2:       m_axis_tready = ((cyc % 10) < 5);
      default: m_axis_tready = 1'b1;
    endcase
  endtask

  task automatic issue_read(input logic [31:0] addr, input logic [7:0] len, input logic id,
                            input logic [1:0] resp);
    logic [7:0] idx;
    logic [31:0] d;
    cur_rresp = resp;
    exp_ar_q.push_back({id, addr, len, 3'd2, 2'b01});
    for (int i = 0; i <= int'(len); i++) begin
      idx = addr[9:2] + i[7:0];
      d = mem[idx];
      exp_r_q.push_back({id, resp, (i == int'(len)), d});
      exp_t_q.push_back({1'b0, (i == int'(len)), 4'hF, d});
    end
    ar_pend = 1'b1;
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
    s_axi_arsize = 3'd2; s_axi_arburst = 2'b01; s_axi_arvalid = 1'b1;
  endtask

  task automatic issue_write(input logic [31:0] addr, input logic [7:0] len, input logic id,
                             input logic [1:0] resp, input logic directed);
    logic [31:0] d;
    logic [3:0] s;
    cur_bresp = resp;
    exp_aw_q.push_back({id, addr, len, 3'd2, 2'b01});
    for (int i = 0; i <= int'(len); i++) begin
      d = (directed && i < 2) ? dir_w[i] : $urandom;
      s = directed ? 4'hF : 4'($urandom_range(1, 15));
      w_q.push_back({s, (i == int'(len)), d});
      exp_mw_q.push_back({s, (i == int'(len)), d});
      exp_t_q.push_back({1'b1, (i == int'(len)), s, d});
    end
    exp_b_q.push_back({id, resp});
    aw_pend = 1'b1;
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
    s_axi_awsize = 3'd2; s_axi_awburst = 2'b01; s_axi_awvalid = 1'b1;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while ((ar_pend || aw_pend || exp_ar_q.size() > 0 || exp_aw_q.size() > 0 ||
            exp_t_q.size() > 0 || exp_r_q.size() > 0 || exp_mw_q.size() > 0 ||
            exp_b_q.size() > 0) && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_done_in_budget"}, n < budget, 1'b1);
    if (n >= budget) begin
      $display("timeout in %s, dut state %0d", tag, dbg_state);
      clear_env();
    end
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_valids_readies"},
        {s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid, s_axi_rvalid,
         m_axi_awvalid, m_axi_arvalid, m_axi_wvalid, m_axi_bready, m_axi_rready, m_axis_tvalid},
        11'b0);
    chk({tag, "_m_awaddr"}, m_axi_awaddr, 32'h0);
    chk({tag, "_m_araddr"}, m_axi_araddr, 32'h0);
  endtask

  task automatic release_and_check(input string tag);
    aresetn_0 = 1'b0;
    step();
    chk({tag, "_awready_after_release"}, s_axi_awready, 1'b1);
    chk({tag, "_arready_after_release"}, s_axi_arready, 1'b1);
  endtask

  initial begin
    int n;
    logic [31:0] a;
    aresetn_0 = 1'b1;
    s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0; s_axi_awburst = '0;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0; s_axi_arburst = '0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0;
    s_axi_bready = 1'b1; s_axi_rready = 1'b1;
    m_axi_awready = 1'b1; m_axi_arready = 1'b1; m_axi_wready = 1'b1;
    m_axi_bid = '0; m_axi_bresp = '0; m_axi_rid = '0; m_axi_rdata = '0;
    m_axi_rresp = '0; m_axi_rlast = 1'b0; m_axis_tready = 1'b1;
    clear_env();
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[8'h40] = 32'h11; mem[8'h41] = 32'h22; mem[8'h42] = 32'h33; mem[8'h43] = 32'h44;
    dir_w[0] = 32'hDEADBEEF; dir_w[1] = 32'hCAFEF00D;

    // reset: everything quiet, then address readies open
    step(); step();
    check_quiet("reset");
    release_and_check("reset");

    // single read of 4 beats from 0x100, always ready
    issue_read(32'h100, 8'd3, 1'b0, 2'b00);
    wait_idle("read4", 100);

    // single write of 2 beats with full strobes
    issue_write(32'h200, 8'd1, 1'b1, 2'b00, 1'b1);
    wait_idle("write2", 100);
    chk("write2_mem0", mem[8'h80], 32'hDEADBEEF);
    chk("write2_mem1", mem[8'h81], 32'hCAFEF00D);

    // read under a 5-high/5-low stream ready pattern
    tr_mode = 2;
    issue_read(32'h100, 8'd3, 1'b1, 2'b00);
    wait_idle("read_tready_pattern", 200);
    issue_read(32'h280, 8'd7, 1'b0, 2'b00);
    wait_idle("read8_tready_pattern", 200);
    tr_mode = 0;

    // read and write requested together; read goes first, error responses passed
    issue_read(32'h300, 8'd2, 1'b0, 2'b10);
    issue_write(32'h340, 8'd2, 1'b1, 2'b11, 1'b0);
    wait_idle("read_wins", 200);

    // reset after the first of four write beats
    issue_write(32'h380, 8'd3, 1'b0, 2'b00, 1'b0);
    mw_beats = 0;
    n = 0;
    while (mw_beats < 1 && n < 50) begin step(); n++; end
    chk("mid_write_first_beat_seen", mw_beats, 1);
    clear_env();
    aresetn_0 = 1'b1;
    step();
    check_quiet("mid_reset");
    release_and_check("mid_reset");
    issue_read(32'h380, 8'd3, 1'b1, 2'b00);
    wait_idle("read_after_mid_reset", 100);

    // read then write back to back
    issue_read(32'h100, 8'd1, 1'b0, 2'b00);
    wait_idle("b2b_read", 100);
    issue_write(32'h3C0, 8'd3, 1'b0, 2'b01, 1'b0);
    wait_idle("b2b_write", 100);

    // randomized traffic with random handshake gaps
    rnd_en = 1'b1;
    tr_mode = 1;
    for (int t = 0; t < 24; t++) begin
      a = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      case ($urandom_range(0, 2))
        0: issue_read(a, 8'($urandom_range(0, 7)), 1'($urandom), 2'($urandom));
        1: issue_write(a, 8'($urandom_range(0, 7)), 1'($urandom), 2'($urandom), 1'b0);
        default: begin
          issue_read(a, 8'($urandom_range(0, 7)), 1'($urandom), 2'($urandom));
          issue_write(a ^ 32'h200, 8'($urandom_range(0, 7)), 1'($urandom), 2'($urandom), 1'b0);
        end
      endcase
      wait_idle("random", 600);
    end
    rnd_en = 1'b0;
    tr_mode = 0;
    issue_read(32'h200, 8'd1, 1'b0, 2'b00);
    wait_idle("final_read", 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
